// File: rtl/split_48_if.sv
// split_48_if: input and output handshake bundle for split_48.
// Optional macro SPLIT_LAST_EN adds the dout_last marker.
interface split_48_if #(
   parameter int unsigned DW = 24
);

   logic            din_flag;
   logic [2*DW-1:0] din;
   logic            din_ready;
   logic [DW-1:0]   dout;
   logic            dout_flag;
   logic            dout_ready;
   logic            busy;
`ifdef SPLIT_LAST_EN
   logic            dout_last;
`endif

   // Upstream/downstream environment view
   modport master (
      output din_flag,
      output din,
      input  din_ready,
      input  dout,
      input  dout_flag,
      output dout_ready,
`ifdef SPLIT_LAST_EN
      input  dout_last,
`endif
      input  busy
   );

   // Splitter view
   modport slave (
      input  din_flag,
      input  din,
      output din_ready,
      output dout,
      output dout_flag,
      input  dout_ready,
`ifdef SPLIT_LAST_EN
      output dout_last,
`endif
      output busy
   );

endinterface

// File: rtl/split_48.sv
// split_48: splits one 2*DW-bit word into two DW-bit beats, upper half first.
// Optional macro SPLIT_LAST_EN drives dout_last high while the lower half is presented.
module split_48 #(
   parameter int unsigned DW = 24
) (
   input  logic       clk,
   input  logic       rst,
   split_48_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StHi, StLo} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic [DW-1:0]   lo_buf_q, lo_buf_d;
   logic            dout_flag_q, dout_flag_d;
   logic            din_ready;
   logic            in_xfer;
   logic            out_beat;

   assign in_xfer  = bus.din_flag & din_ready;
   assign out_beat = dout_flag_q & bus.dout_ready;

   // Input ready: LO may take the next word only if its low half leaves this cycle
   always_comb begin
      din_ready = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StIdle:  din_ready = 1'b1;
            StHi:    din_ready = 1'b0;
            StLo:    din_ready = bus.dout_ready;
            default: din_ready = 1'b0;
         endcase
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      dout_d      = dout_q;
      lo_buf_d    = lo_buf_q;
      dout_flag_d = dout_flag_q;
      unique case (state_q)
         StIdle: begin
            if (in_xfer) begin
               dout_d      = bus.din[2*DW-1:DW];
               lo_buf_d    = bus.din[DW-1:0];
               dout_flag_d = 1'b1;
               state_d     = StHi;
            end
         end
         StHi: begin
            if (out_beat) begin
               dout_d  = lo_buf_q;
               state_d = StLo;
            end
         end
         StLo: begin
            if (out_beat) begin
               if (in_xfer) begin
                  // Reload without a bubble
                  dout_d   = bus.din[2*DW-1:DW];
                  lo_buf_d = bus.din[DW-1:0];
                  state_d  = StHi;
               end else begin
                  dout_flag_d = 1'b0;
                  state_d     = StIdle;
               end
            end
         end
         default: begin
            state_d     = StIdle;
            dout_flag_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         dout_q      <= '0;
         lo_buf_q    <= '0;
         dout_flag_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dout_q      <= dout_d;
         lo_buf_q    <= lo_buf_d;
         dout_flag_q <= dout_flag_d;
      end
   end

`ifdef SPLIT_LAST_EN
   logic last_q;

   // Marker follows state: LO always has dout_flag set, so it tracks the low-half beat
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b0;
      end else begin
         last_q <= (state_d == StLo);
      end
   end

   assign bus.dout_last = last_q;
`endif

   assign bus.din_ready = din_ready;
   assign bus.dout      = dout_q;
   assign bus.dout_flag = dout_flag_q;
   assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_split_48.sv
// tb_split_48: directed scoreboard bench for split_48.
module tb_split_48;

   localparam int unsigned DW = 24;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   // Expected beats: {last, dout}
   logic [DW:0] exp_q[$];

   split_48_if #(.DW(DW)) bus ();

   split_48 #(.DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [DW-1:0] d, input logic last);
      exp_q.push_back({last, d});
   endtask

   // Monitor: every output beat must match the head of the scoreboard
   always @(negedge clk) begin
      logic [DW:0] e;
      if (!rst && bus.dout_flag === 1'b1 && bus.dout_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: got %h expected no beat at %0t", bus.dout, $time);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", 48'(bus.dout), 48'(e[DW-1:0]));
`ifdef SPLIT_LAST_EN
            chk("beat_last", 48'(bus.dout_last), 48'(e[DW]));
`endif
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst            = 1'b1;
      bus.din_flag   = 1'b0;
      bus.din        = '0;
      bus.dout_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("rst_dout", 48'(bus.dout), 48'h0);
      chk("rst_flag", 48'(bus.dout_flag), 48'h0);
      chk("rst_busy", 48'(bus.busy), 48'h0);
      chk("rst_din_ready", 48'(bus.din_ready), 48'h0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_din_ready", 48'(bus.din_ready), 48'h1);

      // Single word with dout_ready high
      step();
      bus.din      = 48'hABCDEF_123456;
      bus.din_flag = 1'b1;
      push(24'hABCDEF, 1'b0);
      push(24'h123456, 1'b1);
      step();
      bus.din_flag = 1'b0;
      @(negedge clk);
      chk("sw_hi_flag", 48'(bus.dout_flag), 48'h1);
      chk("sw_hi_data", 48'(bus.dout), 48'hABCDEF);
      chk("sw_busy", 48'(bus.busy), 48'h1);
      step();
      @(negedge clk);
      chk("sw_lo_data", 48'(bus.dout), 48'h123456);
      chk("sw_lo_flag", 48'(bus.dout_flag), 48'h1);
      step();
      @(negedge clk);
      chk("sw_end_flag", 48'(bus.dout_flag), 48'h0);
      chk("sw_end_busy", 48'(bus.busy), 48'h0);
      chk("sw_end_hold", 48'(bus.dout), 48'h123456);

      // Back-to-back words
      step();
      bus.din      = 48'h000001_000002;
      bus.din_flag = 1'b1;
      push(24'h000001, 1'b0);
      push(24'h000002, 1'b1);
      @(negedge clk);
      chk("b2b_rdy0", 48'(bus.din_ready), 48'h1);
      step();
      bus.din = 48'h000003_000004;
      push(24'h000003, 1'b0);
      push(24'h000004, 1'b1);
      @(negedge clk);
      chk("b2b_rdy1", 48'(bus.din_ready), 48'h0);
      chk("b2b_d1", 48'(bus.dout), 48'h000001);
      step();
      @(negedge clk);
      chk("b2b_rdy2", 48'(bus.din_ready), 48'h1);
      chk("b2b_d2", 48'(bus.dout), 48'h000002);
      step();
      bus.din_flag = 1'b0;
      @(negedge clk);
      chk("b2b_rdy3", 48'(bus.din_ready), 48'h0);
      chk("b2b_d3", 48'(bus.dout), 48'h000003);
      step();
      @(negedge clk);
      chk("b2b_d4", 48'(bus.dout), 48'h000004);
      chk("b2b_d4_flag", 48'(bus.dout_flag), 48'h1);
      step();
      step();

      // Backpressure while the upper half is presented
      bus.dout_ready = 1'b0;
      bus.din        = 48'h111111_222222;
      bus.din_flag   = 1'b1;
      push(24'h111111, 1'b0);
      push(24'h222222, 1'b1);
      step();
      bus.din = 48'hDEAD00_BEEF00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bph_data", 48'(bus.dout), 48'h111111);
         chk("bph_flag", 48'(bus.dout_flag), 48'h1);
         chk("bph_din_ready", 48'(bus.din_ready), 48'h0);
         step();
         bus.din = bus.din + 48'h1;
      end
      bus.din_flag   = 1'b0;
      bus.dout_ready = 1'b1;
      step();
      @(negedge clk);
      chk("bph_lo", 48'(bus.dout), 48'h222222);
      step();
      step();

      // Backpressure in LO with a new word waiting
      bus.din      = 48'hAAAAAA_BBBBBB;
      bus.din_flag = 1'b1;
      push(24'hAAAAAA, 1'b0);
      push(24'hBBBBBB, 1'b1);
      step();
      bus.din_flag = 1'b0;
      step();
      bus.dout_ready = 1'b0;
      bus.din_flag   = 1'b1;
      bus.din        = 48'hCCCCCC_DDDDDD;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bpl_data", 48'(bus.dout), 48'hBBBBBB);
         chk("bpl_din_ready", 48'(bus.din_ready), 48'h0);
`ifdef SPLIT_LAST_EN
         chk("bpl_last", 48'(bus.dout_last), 48'h1);
`endif
         step();
         bus.din = bus.din ^ 48'h0F0F0F_F0F0F0;
      end
      bus.din        = 48'h333333_444444;
      bus.dout_ready = 1'b1;
      push(24'h333333, 1'b0);
      push(24'h444444, 1'b1);
      @(negedge clk);
      chk("bpl_release_rdy", 48'(bus.din_ready), 48'h1);
      step();
      bus.din_flag = 1'b0;
      @(negedge clk);
      chk("bpl_nobubble_flag", 48'(bus.dout_flag), 48'h1);
      chk("bpl_nobubble_data", 48'(bus.dout), 48'h333333);
      step();
      step();
      step();

      // Reset while in HI: the pending low half must vanish
      bus.dout_ready = 1'b0;
      bus.din        = 48'h555555_666666;
      bus.din_flag   = 1'b1;
      step();
      bus.din_flag = 1'b0;
      @(negedge clk);
      chk("rsthi_busy_pre", 48'(bus.busy), 48'h1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.dout_ready = 1'b1;
      @(negedge clk);
      chk("rsthi_dout", 48'(bus.dout), 48'h0);
      chk("rsthi_flag", 48'(bus.dout_flag), 48'h0);
      chk("rsthi_busy", 48'(bus.busy), 48'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("rsthi_quiet", 48'(bus.dout_flag), 48'h0);
      end

      // Drain: every expected beat must have appeared
      begin
         int n;
         n = 0;
         while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
         end
         chk("drain_left", 48'(exp_q.size()), 48'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
